// File: rtl/busca_instrucao_pipe.sv
// Instruction-fetch stage for the pipelined MIPS datapath: PC register, PC+step adder,
// branch/jump select, word-addressed instruction memory with a load port and the IF/ID register.
module busca_instrucao_pipe #(
    parameter int                 LARGURA      = 32,
    parameter int                 PROFUNDIDADE = 256,
    parameter logic [LARGURA-1:0] PC_INICIAL   = '0,
    parameter int                 INCREMENTO   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               PCescreve,
    input  logic               c1,
    input  logic [LARGURA-1:0] alvoDesvio,
    input  logic               flush,
    input  logic               escreveInstr,
    input  logic [LARGURA-1:0] enderecoCarga,
    input  logic [31:0]        dadoCarga,
    output logic [LARGURA-1:0] Pcsaida,
    output logic [LARGURA-1:0] saidaAdder,
    output logic [31:0]        instrIFID,
    output logic [LARGURA-1:0] pcMais4IFID,
    output logic               validoIFID,
    output logic               erroEndereco
);

    localparam int ENDW = $clog2(PROFUNDIDADE);

    logic [31:0]        mem [PROFUNDIDADE];

    logic [LARGURA-1:0] pc_p0;
    logic [LARGURA-1:0] pc_prox_p0;
    logic [LARGURA-1:0] pc_mais_p0;
    logic [ENDW-1:0]    idx_leitura_p0;
    logic [ENDW-1:0]    idx_carga;
    logic               pc_na_faixa_p0;
    logic               carga_na_faixa;
    logic [31:0]        instr_lida_p0;
    logic               erro_p0;

    logic [31:0]        instr_p1;
    logic [LARGURA-1:0] pcmais4_p1;
    logic               vld_p1;

    // Stage 0: PC, adder, next-PC select and combinational fetch
    // Range tests shift away the word-index bits so they stay valid when LARGURA == ENDW+2.
    assign pc_mais_p0     = pc_p0 + LARGURA'(INCREMENTO);
    assign pc_prox_p0     = c1 ? (alvoDesvio & ~LARGURA'(3)) : pc_mais_p0;
    assign idx_leitura_p0 = ENDW'(pc_p0 >> 2);
    assign pc_na_faixa_p0 = ((pc_p0 >> (ENDW + 2)) == '0);
    assign instr_lida_p0  = pc_na_faixa_p0 ? mem[idx_leitura_p0] : 32'h0;

    assign idx_carga      = ENDW'(enderecoCarga >> 2);
    assign carga_na_faixa = ((enderecoCarga >> (ENDW + 2)) == '0);

    // Program memory is never cleared by reset; a same-edge write is seen by the next fetch only.
    always_ff @(posedge clock) begin
        if (escreveInstr && carga_na_faixa) begin
            mem[idx_carga] <= dadoCarga;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_p0   <= PC_INICIAL;
            erro_p0 <= 1'b0;
        end else if (PCescreve) begin
            pc_p0 <= pc_prox_p0;
            if (!pc_na_faixa_p0) begin
                erro_p0 <= 1'b1;
            end
        end
    end

    // Stage 1: IF/ID register; flush wins over stall
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            instr_p1   <= 32'h0;
            pcmais4_p1 <= '0;
            vld_p1     <= 1'b0;
        end else if (PCescreve) begin
            instr_p1   <= instr_lida_p0;
            pcmais4_p1 <= pc_mais_p0;
            vld_p1     <= 1'b1;
        end
    end

    assign Pcsaida      = pc_p0;
    assign saidaAdder   = pc_mais_p0;
    assign instrIFID    = instr_p1;
    assign pcMais4IFID  = pcmais4_p1;
    assign validoIFID   = vld_p1;
    assign erroEndereco = erro_p0;

endmodule
